// File: rtl/refresh_scheduler.sv
// -----------------------------------------------------------------------------
// refresh_scheduler
//
// Turns the single-cycle refresh tick from the refresh interval counter into
// refresh requests for the DRAM command FSM. Keeps a backlog of postponed
// refreshes, asks for a refresh when the host side is idle or the backlog is
// urgent, and holds the bank busy for tRFC after every accepted refresh.
//
// Parameters
//   MAX_PENDING    maximum postponed refreshes (1..15)
//   URGENT_THRESH  backlog that forces a refresh regardless of host activity
//   T_RFC          refresh cycle time in clk cycles (1..255)
//
// Ports
//   clk            clock, all state on rising edge
//   rst            asynchronous, active-low reset
//   refresh_tick   one-cycle pulse: one refresh interval elapsed
//   host_idle      arbiter has no read/write pending this cycle
//   ref_ack        command FSM issued REFRESH (only honoured while ref_req=1)
//   ref_req        registered refresh request
//   ref_urgent     backlog >= URGENT_THRESH, arbiter must stall host traffic
//   ref_busy       registered, tRFC window active
//   pending        registered outstanding refresh count
//   ref_overflow   sticky, a tick arrived while the backlog was full
//   ref_issued_cnt acknowledged refresh count
//
// Build option
//   REF_STATS_EN   when defined, ref_issued_cnt counts accepted acks and
//                  saturates at 16'hFFFF; otherwise it is tied to zero.
// -----------------------------------------------------------------------------
module refresh_scheduler #(
  parameter int MAX_PENDING   = 8,
  parameter int URGENT_THRESH = 6,
  parameter int T_RFC         = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        refresh_tick,
  input  logic        host_idle,
  input  logic        ref_ack,
  output logic        ref_req,
  output logic        ref_urgent,
  output logic        ref_busy,
  output logic [3:0]  pending,
  output logic        ref_overflow,
  output logic [15:0] ref_issued_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    RFC_WAIT = 2'd2
  } state_t;

  localparam logic [3:0] MAX_P  = 4'(MAX_PENDING);
  localparam logic [3:0] URG    = 4'(URGENT_THRESH);
  localparam logic [7:0] T_LOAD = 8'(T_RFC - 1);

  state_t     state, state_nxt;
  logic [7:0] timer, timer_nxt;
  logic       ack_accept;

  // An ack only counts while a request is actually outstanding.
  assign ack_accept = (state == REQ) && ref_ack;
  assign ref_urgent = (pending >= URG);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    case (state)
      IDLE: begin
        if ((pending != 4'd0) && (host_idle || ref_urgent)) state_nxt = REQ;
      end
      REQ: begin
        // Request is held until acked; host_idle dropping does not withdraw it.
        if (ref_ack) begin
          state_nxt = RFC_WAIT;
          timer_nxt = T_LOAD;
        end
      end
      RFC_WAIT: begin
        if (timer == 8'd0) state_nxt = IDLE;
        else               timer_nxt = timer - 8'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      timer    <= 8'd0;
      ref_req  <= 1'b0;
      ref_busy <= 1'b0;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      // Outputs come from flops fed by next-state, so ref_ack has no
      // combinational path to ref_req.
      ref_req  <= (state_nxt == REQ);
      ref_busy <= (state_nxt == RFC_WAIT);
    end
  end

  // Backlog: a tick and an accepted ack in the same cycle cancel out, which
  // also covers the full-backlog case without flagging overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending      <= 4'd0;
      ref_overflow <= 1'b0;
    end else begin
      case ({refresh_tick, ack_accept})
        2'b10: begin
          if (pending == MAX_P) ref_overflow <= 1'b1;
          else                  pending      <= pending + 4'd1;
        end
        2'b01:   pending <= pending - 4'd1;
        default: ;
      endcase
    end
  end

`ifdef REF_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_issued_cnt <= 16'd0;
    end else if (ack_accept && (ref_issued_cnt != 16'hFFFF)) begin
      ref_issued_cnt <= ref_issued_cnt + 16'd1;
    end
  end
`else
  assign ref_issued_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_refresh_scheduler.sv
module tb_refresh_scheduler;

  localparam int MAX_P  = 8;
  localparam int URG    = 6;
  localparam int T_RFC  = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        refresh_tick = 1'b0;
  logic        host_idle = 1'b0;
  logic        ref_ack = 1'b0;
  logic        ref_req, ref_urgent, ref_busy, ref_overflow;
  logic [3:0]  pending;
  logic [15:0] ref_issued_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: backlog count, an outstanding-request flag and the
  // number of busy cycles still to run.
  int m_pending;
  bit m_req;
  int m_busy_left;
  bit m_ovf;
  int m_cnt;

  refresh_scheduler #(
    .MAX_PENDING  (MAX_P),
    .URGENT_THRESH(URG),
    .T_RFC        (T_RFC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .refresh_tick  (refresh_tick),
    .host_idle     (host_idle),
    .ref_ack       (ref_ack),
    .ref_req       (ref_req),
    .ref_urgent    (ref_urgent),
    .ref_busy      (ref_busy),
    .pending       (pending),
    .ref_overflow  (ref_overflow),
    .ref_issued_cnt(ref_issued_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pending   = 0;
    m_req       = 0;
    m_busy_left = 0;
    m_ovf       = 0;
    m_cnt       = 0;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, and return
  // 1 ns after the edge so outputs can be sampled.
  task automatic step(input bit t, input bit h, input bit a);
    bit acc, was_free;
    int np;
    refresh_tick = t;
    host_idle    = h;
    ref_ack      = a;
    @(posedge clk);
    acc      = m_req && a;
    was_free = !m_req && (m_busy_left == 0);
    if (m_busy_left > 0) m_busy_left--;
    if (m_req) begin
      if (a) begin
        m_req       = 0;
        m_busy_left = T_RFC;
      end
    end else if (was_free && m_pending > 0 && (h || m_pending >= URG)) begin
      m_req = 1;
    end
    np = m_pending + int'(t) - int'(acc);
    if (np > MAX_P) begin
      np    = MAX_P;
      m_ovf = 1;
    end
    m_pending = np;
`ifdef REF_STATS_EN
    if (acc && m_cnt < 65535) m_cnt++;
`endif
    #1;
  endtask

  // Serve every request until the backlog is empty and the bank is free.
  task automatic drain();
    int i;
    for (i = 0; i < 3000; i++) begin
      if (m_pending == 0 && !m_req && m_busy_left == 0) break;
      step(0, 1, m_req);
    end
    n_cmp++;
    if (i >= 3000 || pending !== 4'd0) begin
      n_bad++;
      $display("FAIL drain: pending=%0d after %0d cycles, required 0", pending, i);
    end
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (ref_req !== 1'b0)        begin n_bad++; $display("FAIL rst_req: got %b exp 0", ref_req); end
    n_cmp++; if (ref_busy !== 1'b0)       begin n_bad++; $display("FAIL rst_busy: got %b exp 0", ref_busy); end
    n_cmp++; if (pending !== 4'd0)        begin n_bad++; $display("FAIL rst_pending: got %0d exp 0", pending); end
    n_cmp++; if (ref_urgent !== 1'b0)     begin n_bad++; $display("FAIL rst_urgent: got %b exp 0", ref_urgent); end
    n_cmp++; if (ref_overflow !== 1'b0)   begin n_bad++; $display("FAIL rst_ovf: got %b exp 0", ref_overflow); end
    n_cmp++; if (ref_issued_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_cnt: got %0d exp 0", ref_issued_cnt); end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    int n;
    step(1, 1, 0);
    n_cmp++; if (pending !== 4'd1) begin n_bad++; $display("FAIL single_pend1: got %0d exp 1", pending); end
    n_cmp++; if (ref_req !== 1'b0) begin n_bad++; $display("FAIL single_latency: got req=%b exp 0", ref_req); end
    step(0, 1, 0);
    n_cmp++; if (ref_req !== 1'b1) begin n_bad++; $display("FAIL single_req: got %b exp 1", ref_req); end
    step(0, 0, 0);
    n_cmp++; if (ref_req !== 1'b1) begin n_bad++; $display("FAIL single_req_hold: got %b exp 1", ref_req); end
    step(0, 1, 1);
    n_cmp++; if (ref_req !== 1'b0 || ref_busy !== 1'b1 || pending !== 4'd0) begin
      n_bad++; $display("FAIL single_ack: got req=%b busy=%b pend=%0d exp 0/1/0", ref_req, ref_busy, pending);
    end
    n = 1;
    for (int i = 0; i < 100; i++) begin
      step(0, 1, 0);
      if (ref_busy) n++;
      else break;
    end
    n_cmp++; if (n !== T_RFC) begin n_bad++; $display("FAIL single_busy_len: got %0d exp %0d", n, T_RFC); end
    n_cmp++; if (ref_req !== 1'b0 || ref_busy !== 1'b0) begin
      n_bad++; $display("FAIL single_idle: got req=%b busy=%b exp 0/0", ref_req, ref_busy);
    end
    n_cmp++; if (ref_issued_cnt !== 16'(m_cnt)) begin
      n_bad++; $display("FAIL single_cnt: got %0d exp %0d", ref_issued_cnt, m_cnt);
    end
  endtask

  task automatic test_urgent();
    for (int k = 1; k <= URG; k++) begin
      step(1, 0, 0);
      n_cmp++; if (ref_req !== 1'b0 || pending !== 4'(k)) begin
        n_bad++; $display("FAIL urgent_tick%0d: got req=%b pend=%0d exp 0/%0d", k, ref_req, pending, k);
      end
      n_cmp++; if (ref_urgent !== (k >= URG)) begin
        n_bad++; $display("FAIL urgent_flag%0d: got %b exp %b", k, ref_urgent, k >= URG);
      end
    end
    step(0, 0, 0);
    n_cmp++; if (ref_req !== 1'b1) begin n_bad++; $display("FAIL urgent_req: got %b exp 1", ref_req); end
    drain();
  endtask

  task automatic test_overflow();
    for (int k = 1; k <= MAX_P; k++) step(1, 0, 0);
    n_cmp++; if (pending !== 4'(MAX_P) || ref_overflow !== 1'b0 || ref_req !== 1'b1) begin
      n_bad++; $display("FAIL ovf_full: got pend=%0d ovf=%b req=%b exp %0d/0/1", pending, ref_overflow, ref_req, MAX_P);
    end
    step(1, 0, 1);
    n_cmp++; if (pending !== 4'(MAX_P) || ref_overflow !== 1'b0 || ref_busy !== 1'b1) begin
      n_bad++; $display("FAIL ovf_tick_ack: got pend=%0d ovf=%b busy=%b exp %0d/0/1", pending, ref_overflow, ref_busy, MAX_P);
    end
    step(1, 0, 0);
    n_cmp++; if (pending !== 4'(MAX_P) || ref_overflow !== 1'b1) begin
      n_bad++; $display("FAIL ovf_set: got pend=%0d ovf=%b exp %0d/1", pending, ref_overflow, MAX_P);
    end
    drain();
    n_cmp++; if (ref_overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b exp 1", ref_overflow); end
  endtask

  task automatic test_tick_ack();
    for (int k = 0; k < 3; k++) step(1, 0, 0);
    step(0, 1, 0);
    n_cmp++; if (ref_req !== 1'b1 || pending !== 4'd3) begin
      n_bad++; $display("FAIL tick_ack_pre: got req=%b pend=%0d exp 1/3", ref_req, pending);
    end
    step(1, 1, 1);
    n_cmp++; if (pending !== 4'd3 || ref_busy !== 1'b1 || ref_req !== 1'b0) begin
      n_bad++; $display("FAIL tick_ack: got pend=%0d busy=%b req=%b exp 3/1/0", pending, ref_busy, ref_req);
    end
  endtask

  task automatic test_ack_ignored();
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1);
      n_cmp++; if (pending !== 4'd3 || ref_busy !== 1'b1 || ref_issued_cnt !== 16'(m_cnt)) begin
        n_bad++; $display("FAIL ack_in_rfc: got pend=%0d busy=%b cnt=%0d exp 3/1/%0d", pending, ref_busy, ref_issued_cnt, m_cnt);
      end
    end
    for (int i = 0; i < 100 && ref_busy; i++) step(0, 0, 0);
    n_cmp++; if (ref_busy !== 1'b0) begin n_bad++; $display("FAIL ack_wait_busy: got %b exp 0", ref_busy); end
    for (int k = 0; k < 2; k++) begin
      step(0, 0, 1);
      n_cmp++; if (pending !== 4'd3 || ref_req !== 1'b0 || ref_busy !== 1'b0 || ref_issued_cnt !== 16'(m_cnt)) begin
        n_bad++; $display("FAIL ack_in_idle: got pend=%0d req=%b busy=%b cnt=%0d exp 3/0/0/%0d", pending, ref_req, ref_busy, ref_issued_cnt, m_cnt);
      end
    end
  endtask

  task automatic test_mid_reset();
    step(1, 0, 0);
    step(0, 1, 0);
    step(1, 0, 1);
    for (int k = 0; k < 5; k++) step(0, 0, 0);
    n_cmp++; if (pending !== 4'd4 || ref_busy !== 1'b1) begin
      n_bad++; $display("FAIL mrst_pre: got pend=%0d busy=%b exp 4/1", pending, ref_busy);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if ({ref_req, ref_busy, ref_urgent, ref_overflow} !== 4'b0 || pending !== 4'd0 || ref_issued_cnt !== 16'd0) begin
      n_bad++; $display("FAIL mrst_clear: got req=%b busy=%b urg=%b ovf=%b pend=%0d cnt=%0d exp all 0",
                        ref_req, ref_busy, ref_urgent, ref_overflow, pending, ref_issued_cnt);
    end
    model_reset();
    #2 rst = 1'b1;
    step(0, 1, 0);
    step(0, 1, 0);
    n_cmp++; if (ref_req !== 1'b0 || ref_busy !== 1'b0 || pending !== 4'd0) begin
      n_bad++; $display("FAIL mrst_after: got req=%b busy=%b pend=%0d exp 0/0/0", ref_req, ref_busy, pending);
    end
  endtask

  task automatic test_random();
    bit t, h, a;
    int tick_pct, idle_pct;
    int bad_before;
    for (int ph = 0; ph < 4; ph++) begin
      tick_pct = (ph == 2) ? 15 : (ph == 3) ? 4 : 8;
      idle_pct = (ph == 2) ? 5 : (ph == 1) ? 80 : 40;
      for (int c = 0; c < 800; c++) begin
        t = ($urandom_range(0, 99) < tick_pct);
        h = ($urandom_range(0, 99) < idle_pct);
        a = m_req ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
        step(t, h, a);
        bad_before = n_bad;
        n_cmp++; if (ref_req !== m_req)            begin n_bad++; $display("FAIL rnd_req: got %b exp %b", ref_req, m_req); end
        n_cmp++; if (ref_busy !== (m_busy_left > 0)) begin n_bad++; $display("FAIL rnd_busy: got %b exp %b", ref_busy, m_busy_left > 0); end
        n_cmp++; if (pending !== 4'(m_pending))    begin n_bad++; $display("FAIL rnd_pending: got %0d exp %0d", pending, m_pending); end
        n_cmp++; if (ref_urgent !== (m_pending >= URG)) begin n_bad++; $display("FAIL rnd_urgent: got %b exp %b", ref_urgent, m_pending >= URG); end
        n_cmp++; if (ref_overflow !== m_ovf)       begin n_bad++; $display("FAIL rnd_ovf: got %b exp %b", ref_overflow, m_ovf); end
        n_cmp++; if (ref_issued_cnt !== 16'(m_cnt)) begin n_bad++; $display("FAIL rnd_cnt: got %0d exp %0d", ref_issued_cnt, m_cnt); end
        if (n_bad > bad_before + 20) return;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_urgent();
    test_overflow();
    test_tick_ack();
    test_ack_ignored();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
